// File: rtl/bbc_csr_master.sv
// CSR bus initiator: turns single host commands into csr_request transactions,
// collects the csr_response and reports completion, error or timeout.
module bbc_csr_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset_n,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read_not_write,
  input  logic [15:0] cmd_select,
  input  logic [15:0] cmd_address,
  input  logic [31:0] cmd_data,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic [31:0] rsp_data,

  output logic        csr_request__valid,
  output logic        csr_request__read_not_write,
  output logic [15:0] csr_request__select,
  output logic [15:0] csr_request__address,
  output logic [31:0] csr_request__data,

  input  logic        csr_response__acknowledge,
  input  logic        csr_response__read_data_valid,
  input  logic        csr_response__read_data_error,
  input  logic [31:0] csr_response__read_data,

  output logic [7:0]  timeout_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } state_e;

  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

  state_e      state_q;
  logic [7:0]  timer_q;
  logic [7:0]  timer_d;
  logic [7:0]  timeout_count_q;
  logic [7:0]  timeout_count_d;
  logic        timeout_hit;

  logic        req_valid_q;
  logic        req_rnw_q;
  logic [15:0] req_select_q;
  logic [15:0] req_address_q;
  logic [31:0] req_data_q;

  logic        rsp_valid_q;
  logic        rsp_error_q;
  logic        rsp_timeout_q;
  logic [31:0] rsp_data_q;

  // Timer saturates so a disabled timeout never wraps into a false match.
  always_comb begin
    timer_d         = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
    timeout_count_d = (timeout_count_q == 8'hFF) ? timeout_count_q
                                                 : timeout_count_q + 8'd1;
    timeout_hit     = (TIMEOUT_CYCLES != 0) && (timer_q == TimeoutLimit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      timer_q         <= 8'd0;
      timeout_count_q <= 8'd0;
      req_valid_q     <= 1'b0;
      req_rnw_q       <= 1'b0;
      req_select_q    <= 16'd0;
      req_address_q   <= 16'd0;
      req_data_q      <= 32'd0;
      rsp_valid_q     <= 1'b0;
      rsp_error_q     <= 1'b0;
      rsp_timeout_q   <= 1'b0;
      rsp_data_q      <= 32'd0;
    end else if (clk__enable) begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            req_valid_q   <= 1'b1;
            req_rnw_q     <= cmd_read_not_write;
            req_select_q  <= cmd_select;
            req_address_q <= cmd_address;
            req_data_q    <= cmd_data;
            timer_q       <= 8'd0;
            state_q       <= REQ;
          end
        end

        REQ: begin
          if (csr_response__acknowledge) begin
            req_valid_q <= 1'b0;
            if (!req_rnw_q) begin
              rsp_valid_q   <= 1'b1;
              rsp_error_q   <= 1'b0;
              rsp_timeout_q <= 1'b0;
              rsp_data_q    <= 32'd0;
              state_q       <= RESP;
            end else if (csr_response__read_data_valid) begin
              rsp_valid_q   <= 1'b1;
              rsp_error_q   <= csr_response__read_data_error;
              rsp_timeout_q <= 1'b0;
              rsp_data_q    <= csr_response__read_data;
              state_q       <= RESP;
            end else begin
              timer_q <= 8'd0;
              state_q <= READ_WAIT;
            end
          end else if (timeout_hit) begin
            req_valid_q     <= 1'b0;
            rsp_valid_q     <= 1'b1;
            rsp_error_q     <= 1'b0;
            rsp_timeout_q   <= 1'b1;
            rsp_data_q      <= 32'd0;
            timeout_count_q <= timeout_count_d;
            state_q         <= RESP;
          end else begin
            timer_q <= timer_d;
          end
        end

        // Acknowledges arriving here are stray and deliberately ignored.
        READ_WAIT: begin
          if (csr_response__read_data_valid) begin
            rsp_valid_q   <= 1'b1;
            rsp_error_q   <= csr_response__read_data_error;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= csr_response__read_data;
            state_q       <= RESP;
          end else if (timeout_hit) begin
            rsp_valid_q     <= 1'b1;
            rsp_error_q     <= 1'b0;
            rsp_timeout_q   <= 1'b1;
            rsp_data_q      <= 32'd0;
            timeout_count_q <= timeout_count_d;
            state_q         <= RESP;
          end else begin
            timer_q <= timer_d;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready                   = (state_q == IDLE);
  assign rsp_valid                   = rsp_valid_q;
  assign rsp_error                   = rsp_error_q;
  assign rsp_timeout                 = rsp_timeout_q;
  assign rsp_data                    = rsp_data_q;
  assign csr_request__valid          = req_valid_q;
  assign csr_request__read_not_write = req_rnw_q;
  assign csr_request__select         = req_select_q;
  assign csr_request__address        = req_address_q;
  assign csr_request__data           = req_data_q;
  assign timeout_count               = timeout_count_q;

endmodule

// File: tb/tb_bbc_csr_master.sv
// Directed self-checking bench for bbc_csr_master, built with a 4-cycle timeout
// so timeout and saturation scenarios stay short.
module tb_bbc_csr_master;

  logic        clk;
  logic        clkEn;
  logic        resetN;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdRnw;
  logic [15:0] cmdSelect;
  logic [15:0] cmdAddress;
  logic [31:0] cmdData;
  logic        rspValid;
  logic        rspReady;
  logic        rspError;
  logic        rspTimeout;
  logic [31:0] rspData;
  logic        reqValid;
  logic        reqRnw;
  logic [15:0] reqSelect;
  logic [15:0] reqAddress;
  logic [31:0] reqData;
  logic        ack;
  logic        rdValid;
  logic        rdError;
  logic [31:0] rdData;
  logic [7:0]  timeoutCount;

  int checks;
  int failures;

  bbc_csr_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk                           (clk),
    .clk__enable                   (clkEn),
    .reset_n                       (resetN),
    .cmd_valid                     (cmdValid),
    .cmd_ready                     (cmdReady),
    .cmd_read_not_write            (cmdRnw),
    .cmd_select                    (cmdSelect),
    .cmd_address                   (cmdAddress),
    .cmd_data                      (cmdData),
    .rsp_valid                     (rspValid),
    .rsp_ready                     (rspReady),
    .rsp_error                     (rspError),
    .rsp_timeout                   (rspTimeout),
    .rsp_data                      (rspData),
    .csr_request__valid            (reqValid),
    .csr_request__read_not_write   (reqRnw),
    .csr_request__select           (reqSelect),
    .csr_request__address          (reqAddress),
    .csr_request__data             (reqData),
    .csr_response__acknowledge     (ack),
    .csr_response__read_data_valid (rdValid),
    .csr_response__read_data_error (rdError),
    .csr_response__read_data       (rdData),
    .timeout_count                 (timeoutCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rnw, input logic [15:0] sel,
                               input logic [15:0] addr, input logic [31:0] data);
    cmdRnw     = rnw;
    cmdSelect  = sel;
    cmdAddress = addr;
    cmdData    = data;
    cmdValid   = 1'b1;
    tick;
    cmdValid   = 1'b0;
  endtask

  task automatic consumeResponse;
    rspReady = 1'b1;
    tick;
    rspReady = 1'b0;
  endtask

  task automatic runWriteTimeout;
    applyStimulus(1'b0, 16'h0003, 16'h0010, 32'h0000_0055);
    repeat (5) tick;
    consumeResponse;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    clkEn      = 1'b1;
    resetN     = 1'b0;
    cmdValid   = 1'b0;
    cmdRnw     = 1'b0;
    cmdSelect  = 16'd0;
    cmdAddress = 16'd0;
    cmdData    = 32'd0;
    rspReady   = 1'b0;
    ack        = 1'b0;
    rdValid    = 1'b0;
    rdError    = 1'b0;
    rdData     = 32'd0;

    tick;
    tick;
    checkOutput("rst_cmd_ready", cmdReady, 1);
    checkOutput("rst_req_valid", reqValid, 0);
    checkOutput("rst_rsp_valid", rspValid, 0);
    checkOutput("rst_timeout_count", timeoutCount, 0);
    resetN = 1'b1;
    tick;

    // Write acknowledged in the third valid cycle.
    applyStimulus(1'b0, 16'h0001, 16'h0000, 32'h0002_0B02);
    checkOutput("wr_valid_c0", reqValid, 1);
    checkOutput("wr_cmd_ready_busy", cmdReady, 0);
    checkOutput("wr_select", reqSelect, 32'h0001);
    checkOutput("wr_address", reqAddress, 32'h0000);
    checkOutput("wr_data", reqData, 32'h0002_0B02);
    checkOutput("wr_rnw", reqRnw, 0);
    tick;
    checkOutput("wr_valid_c1", reqValid, 1);
    tick;
    checkOutput("wr_valid_c2", reqValid, 1);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    checkOutput("wr_valid_fall", reqValid, 0);
    checkOutput("wr_rsp_valid", rspValid, 1);
    checkOutput("wr_rsp_error", rspError, 0);
    checkOutput("wr_rsp_timeout", rspTimeout, 0);
    checkOutput("wr_rsp_data", rspData, 0);
    consumeResponse;
    checkOutput("wr_rsp_done", rspValid, 0);
    checkOutput("wr_cmd_ready_back", cmdReady, 1);

    // Read with acknowledge and data in the same cycle.
    applyStimulus(1'b1, 16'h0002, 16'h0004, 32'h0);
    checkOutput("rd0_rnw", reqRnw, 1);
    ack = 1'b1; rdValid = 1'b1; rdData = 32'h0000_020B;
    tick;
    ack = 1'b0; rdValid = 1'b0; rdData = 32'd0;
    checkOutput("rd0_valid_fall", reqValid, 0);
    checkOutput("rd0_rsp_valid", rspValid, 1);
    checkOutput("rd0_rsp_data", rspData, 32'h0000_020B);
    checkOutput("rd0_rsp_error", rspError, 0);
    consumeResponse;

    // Read with error data arriving 5 cycles after acknowledge, on the timeout cycle.
    applyStimulus(1'b1, 16'h0002, 16'h0008, 32'h0);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("rd1_wait_valid_low", reqValid, 0);
      checkOutput("rd1_wait_no_rsp", rspValid, 0);
      tick;
    end
    rdValid = 1'b1; rdError = 1'b1; rdData = 32'hDEAD_BEEF;
    tick;
    rdValid = 1'b0; rdError = 1'b0; rdData = 32'd0;
    checkOutput("rd1_rsp_valid", rspValid, 1);
    checkOutput("rd1_rsp_error", rspError, 1);
    checkOutput("rd1_rsp_data", rspData, 32'hDEAD_BEEF);
    checkOutput("rd1_rsp_timeout", rspTimeout, 0);
    checkOutput("rd1_timeout_count", timeoutCount, 0);
    consumeResponse;

    // Unacknowledged write times out after 5 valid cycles.
    applyStimulus(1'b0, 16'h0005, 16'h0020, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      checkOutput("to_valid_high", reqValid, 1);
      tick;
    end
    checkOutput("to_valid_fall", reqValid, 0);
    checkOutput("to_rsp_valid", rspValid, 1);
    checkOutput("to_rsp_timeout", rspTimeout, 1);
    checkOutput("to_rsp_data", rspData, 0);
    checkOutput("to_count", timeoutCount, 1);
    consumeResponse;
    ack = 1'b1;
    tick;
    tick;
    ack = 1'b0;
    checkOutput("late_ack_idle_ready", cmdReady, 1);
    checkOutput("late_ack_no_rsp", rspValid, 0);
    checkOutput("late_ack_no_valid", reqValid, 0);

    // Read whose data never comes times out in the wait phase.
    applyStimulus(1'b1, 16'h0006, 16'h0030, 32'h0);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    repeat (4) tick;
    checkOutput("rdto_not_yet", rspValid, 0);
    tick;
    checkOutput("rdto_rsp_valid", rspValid, 1);
    checkOutput("rdto_rsp_timeout", rspTimeout, 1);
    checkOutput("rdto_count", timeoutCount, 2);
    consumeResponse;
    rdValid = 1'b1; rdData = 32'hCAFE_0000;
    tick;
    rdValid = 1'b0; rdData = 32'd0;
    checkOutput("late_data_no_rsp", rspValid, 0);

    // Response held off for 10 cycles while a command is offered.
    applyStimulus(1'b1, 16'h0007, 16'h0040, 32'h0);
    ack = 1'b1; rdValid = 1'b1; rdData = 32'h1234_5678;
    tick;
    ack = 1'b0; rdValid = 1'b0; rdData = 32'd0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_rsp_valid", rspValid, 1);
      checkOutput("hold_rsp_data", rspData, 32'h1234_5678);
      checkOutput("hold_cmd_ready", cmdReady, 0);
      cmdValid = (i == 3); cmdAddress = 16'h0BAD; cmdRnw = 1'b0;
      tick;
      cmdValid = 1'b0;
    end
    consumeResponse;
    checkOutput("hold_cmd_ready_back", cmdReady, 1);
    checkOutput("hold_not_accepted", reqValid, 0);
    checkOutput("hold_addr_kept", reqAddress, 32'h0040);

    // Asynchronous reset while waiting for read data.
    applyStimulus(1'b1, 16'h00A5, 16'h0050, 32'h0);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    #2 resetN = 1'b0;
    #1;
    checkOutput("arst_rw_cmd_ready", cmdReady, 1);
    checkOutput("arst_rw_select", reqSelect, 0);
    checkOutput("arst_rw_address", reqAddress, 0);
    checkOutput("arst_rw_rnw", reqRnw, 0);
    checkOutput("arst_rw_count", timeoutCount, 0);
    resetN = 1'b1;
    tick;
    applyStimulus(1'b0, 16'h0001, 16'h0002, 32'h0000_0003);
    checkOutput("arst_req_valid_pre", reqValid, 1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("arst_req_valid", reqValid, 0);
    checkOutput("arst_req_data", reqData, 0);
    resetN = 1'b1;
    tick;

    // Timeout counter saturation.
    for (int i = 0; i < 254; i++) runWriteTimeout;
    checkOutput("sat_count_254", timeoutCount, 32'hFE);
    runWriteTimeout;
    checkOutput("sat_count_255", timeoutCount, 32'hFF);
    for (int i = 0; i < 45; i++) runWriteTimeout;
    checkOutput("sat_count_300", timeoutCount, 32'hFF);

    // Write with the clock enable toggling every cycle.
    cmdRnw = 1'b0; cmdSelect = 16'h0001; cmdAddress = 16'h0000; cmdData = 32'h0002_0B02;
    cmdValid = 1'b1; clkEn = 1'b0;
    tick;
    checkOutput("ce_not_sampled", reqValid, 0);
    clkEn = 1'b1;
    tick;
    cmdValid = 1'b0;
    checkOutput("ce_valid_c0", reqValid, 1);
    clkEn = 1'b0; ack = 1'b1;
    tick;
    ack = 1'b0;
    checkOutput("ce_ack_ignored", reqValid, 1);
    clkEn = 1'b1;
    tick;
    checkOutput("ce_valid_c1", reqValid, 1);
    clkEn = 1'b0;
    tick;
    clkEn = 1'b1;
    tick;
    checkOutput("ce_valid_c2", reqValid, 1);
    ack = 1'b1; clkEn = 1'b0;
    tick;
    checkOutput("ce_hold_valid", reqValid, 1);
    checkOutput("ce_hold_no_rsp", rspValid, 0);
    clkEn = 1'b1;
    tick;
    ack = 1'b0;
    checkOutput("ce_valid_fall", reqValid, 0);
    checkOutput("ce_rsp_valid", rspValid, 1);
    checkOutput("ce_rsp_data", rspData, 0);
    checkOutput("ce_rsp_timeout", rspTimeout, 0);
    rspReady = 1'b1; clkEn = 1'b0;
    tick;
    checkOutput("ce_rsp_held", rspValid, 1);
    clkEn = 1'b1;
    tick;
    rspReady = 1'b0;
    checkOutput("ce_rsp_done", rspValid, 0);
    checkOutput("ce_cmd_ready", cmdReady, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
